// File: rtl/uart_bridge.sv
// uart_bridge: byte-handshake UART responder, 8N1 serial TX/RX each buffered by a FIFO.
// Optional macro UART_BRIDGE_LOOPBACK_EN adds a `loopback` input that feeds the internal txd into RX.
module uart_bridge #(
  parameter int CLK_PER_BIT     = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
`ifdef UART_BRIDGE_LOOPBACK_EN
  input  logic       loopback,
`endif
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_in_data,
  input  logic       uart_in_valid,
  output logic       uart_in_ready,
  input  logic       uart_out_valid,
  output logic [7:0] uart_out_data,
  output logic       uart_out_ready,
  output logic       txd,
  input  logic       rxd,
  output logic       tx_busy,
  output logic       rx_overrun,
  output logic       rx_frame_err
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int NW    = FIFO_DEPTH_LOG2 + 1;
  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] COUNT_FULL = NW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [PW-1:0] r_tx_wptr, r_tx_rptr;
  logic [NW-1:0] r_tx_count, w_tx_count_n;
  logic          r_in_ready, r_tx_busy, r_txd, w_txd_n;
  logic          w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0]    w_tx_head, r_tx_shift, w_tx_shift_n;
  state_t        r_tx_state, w_tx_state_n;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_n;
  logic [2:0]    r_tx_bit, w_tx_bit_n;

  logic [7:0]    r_rx_mem [DEPTH];
  logic [PW-1:0] r_rx_wptr, r_rx_rptr;
  logic [NW-1:0] r_rx_count, w_rx_count_n;
  logic          r_rx_meta, r_rx_sync, r_rx_prev, w_rx_src, w_rx_fall;
  state_t        r_rx_state, w_rx_state_n;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_n;
  logic [2:0]    r_rx_bit, w_rx_bit_n;
  logic [7:0]    r_rx_shift, w_rx_shift_n, r_out_data;
  logic          w_rx_done, w_rx_bad, w_rx_pop, w_rx_push, w_rx_full, w_rx_empty;
  logic          r_out_ready, r_rx_overrun, r_rx_frame_err;

  assign w_tx_full  = (r_tx_count == COUNT_FULL);
  assign w_tx_empty = (r_tx_count == NW'(0));
  assign w_tx_head  = r_tx_mem[r_tx_rptr];
  // Ready is only raised when a slot is free, so the following push can never overflow.
  assign w_tx_push  = uart_in_valid && r_in_ready;

  always_comb begin
    case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_count_n = r_tx_count + NW'(1);
      2'b01:   w_tx_count_n = r_tx_count - NW'(1);
      default: w_tx_count_n = r_tx_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready <= 1'b0;
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else begin
      r_in_ready <= uart_in_valid && !r_in_ready && !w_tx_full;
      r_tx_count <= w_tx_count_n;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= uart_in_data;
  end

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt + CW'(1);
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_txd_n      = r_txd;
    w_tx_pop     = 1'b0;
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_cnt_n = '0;
        if (!w_tx_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_shift_n = w_tx_head;
          w_tx_state_n = ST_START;
          w_txd_n      = 1'b0;
        end else begin
          w_txd_n = 1'b1;
        end
      end
      ST_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_n   = '0;
          w_tx_bit_n   = 3'd0;
          w_txd_n      = r_tx_shift[0];
          w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
          w_tx_state_n = ST_DATA;
        end else begin
          w_txd_n = 1'b0;
        end
      end
      ST_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_n = '0;
          if (r_tx_bit == 3'd7) begin
            w_txd_n      = 1'b1;
            w_tx_state_n = ST_STOP;
          end else begin
            w_tx_bit_n   = r_tx_bit + 3'd1;
            w_txd_n      = r_tx_shift[0];
            w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
          end
        end else begin
          w_tx_bit_n = r_tx_bit;
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit so queued frames leave without an idle gap.
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_n = '0;
          if (!w_tx_empty) begin
            w_tx_pop     = 1'b1;
            w_tx_shift_n = w_tx_head;
            w_tx_state_n = ST_START;
            w_txd_n      = 1'b0;
          end else begin
            w_tx_state_n = ST_IDLE;
          end
        end else begin
          w_txd_n = 1'b1;
        end
      end
      default: begin
        w_tx_state_n = ST_IDLE;
        w_txd_n      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_txd      <= w_txd_n;
      r_tx_busy  <= (w_tx_count_n != NW'(0)) || (w_tx_state_n != ST_IDLE);
    end
  end

`ifdef UART_BRIDGE_LOOPBACK_EN
  assign w_rx_src = loopback ? r_txd : rxd;
`else
  assign w_rx_src = rxd;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= w_rx_src;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // A falling edge needs a high sample first, so a line stuck low after a bad frame is ignored.
  assign w_rx_fall = r_rx_prev && !r_rx_sync;

  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt + CW'(1);
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_done    = 1'b0;
    w_rx_bad     = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        w_rx_cnt_n = '0;
        if (w_rx_fall) w_rx_state_n = ST_START;
        else           w_rx_state_n = ST_IDLE;
      end
      ST_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_n   = '0;
          w_rx_bit_n   = 3'd0;
          w_rx_state_n = r_rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          w_rx_state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_n   = '0;
          w_rx_shift_n = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_bit_n   = r_rx_bit + 3'd1;
          w_rx_state_n = (r_rx_bit == 3'd7) ? ST_STOP : ST_DATA;
        end else begin
          w_rx_state_n = ST_DATA;
        end
      end
      ST_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_n   = '0;
          w_rx_done    = r_rx_sync;
          w_rx_bad     = !r_rx_sync;
          w_rx_state_n = ST_IDLE;
        end else begin
          w_rx_state_n = ST_STOP;
        end
      end
      default: w_rx_state_n = ST_IDLE;
    endcase
  end

  assign w_rx_full  = (r_rx_count == COUNT_FULL);
  assign w_rx_empty = (r_rx_count == NW'(0));
  assign w_rx_pop   = uart_out_valid && !r_out_ready && !w_rx_empty;
  // Pop-then-push: a read on the same edge frees the slot the new byte needs.
  assign w_rx_push  = w_rx_done && (!w_rx_full || w_rx_pop);

  always_comb begin
    case ({w_rx_push, w_rx_pop})
      2'b10:   w_rx_count_n = r_rx_count + NW'(1);
      2'b01:   w_rx_count_n = r_rx_count - NW'(1);
      default: w_rx_count_n = r_rx_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state     <= ST_IDLE;
      r_rx_cnt       <= '0;
      r_rx_bit       <= 3'd0;
      r_rx_shift     <= 8'd0;
      r_rx_wptr      <= '0;
      r_rx_rptr      <= '0;
      r_rx_count     <= '0;
      r_out_ready    <= 1'b0;
      r_out_data     <= 8'd0;
      r_rx_overrun   <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_state_n;
      r_rx_cnt    <= w_rx_cnt_n;
      r_rx_bit    <= w_rx_bit_n;
      r_rx_shift  <= w_rx_shift_n;
      r_rx_count  <= w_rx_count_n;
      r_out_ready <= w_rx_pop;
      if (w_rx_pop)  r_out_data <= r_rx_mem[r_rx_rptr];
      if (w_rx_pop)  r_rx_rptr  <= r_rx_rptr + PW'(1);
      if (w_rx_push) r_rx_wptr  <= r_rx_wptr + PW'(1);
      if (w_rx_done && !w_rx_push) r_rx_overrun <= 1'b1;
      if (w_rx_bad) r_rx_frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= r_rx_shift;
  end

  assign uart_in_ready  = r_in_ready;
  assign uart_out_ready = r_out_ready;
  assign uart_out_data  = r_out_data;
  assign txd            = r_txd;
  assign tx_busy        = r_tx_busy;
  assign rx_overrun     = r_rx_overrun;
  assign rx_frame_err   = r_rx_frame_err;
endmodule

// File: tb/tb_uart_bridge.sv
// Scoreboard bench for uart_bridge: directed stimulus pushes expected bytes, monitors decode and compare.
`timescale 1ns/1ps
module tb_uart_bridge;
  localparam int CPB = 8;
  localparam int DL2 = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] uart_in_data = 8'd0;
  logic       uart_in_valid = 1'b0;
  logic       uart_in_ready;
  logic       uart_out_valid = 1'b0;
  logic [7:0] uart_out_data;
  logic       uart_out_ready;
  logic       txd;
  logic       rxd = 1'b1;
  logic       tx_busy, rx_overrun, rx_frame_err;
`ifdef UART_BRIDGE_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int in_pulses = 0;
  int out_pulses = 0;
  int contig = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  uart_bridge #(.CLK_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DL2)) dut (
`ifdef UART_BRIDGE_LOOPBACK_EN
    .loopback(loopback),
`endif
    .clk(clk), .reset(reset),
    .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid), .uart_in_ready(uart_in_ready),
    .uart_out_valid(uart_out_valid), .uart_out_data(uart_out_data), .uart_out_ready(uart_out_ready),
    .txd(txd), .rxd(rxd), .tx_busy(tx_busy), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // TX monitor: decodes txd frames mid-bit, scores bytes and counts back-to-back frames.
  initial begin : tx_mon
    int cnt;
    bit active;
    logic prev_in;
    logic [7:0] b;
    cnt = 0; active = 1'b0; prev_in = 1'b0; b = 8'd0;
    forever begin
      @(negedge clk);
      if (uart_in_ready) begin
        in_pulses++;
        check("in_ready_one_cycle", {31'd0, prev_in}, 32'd0);
      end
      prev_in = uart_in_ready;
      if (reset) begin
        active = 1'b0;
      end else if (active) begin
        cnt++;
        if (cnt == 4) check("tx_start_bit", {31'd0, txd}, 32'd0);
        else if (cnt >= 12 && cnt <= 68 && (cnt % 8) == 4) b[(cnt - 12) / 8] = txd;
        else if (cnt == 76) begin
          check("tx_stop_bit", {31'd0, txd}, 32'd1);
          check("tx_frame_expected", {31'd0, exp_tx.size() != 0}, 32'd1);
          if (exp_tx.size() != 0) check("tx_byte", {24'd0, b}, {24'd0, exp_tx.pop_front()});
        end else if (cnt == 80) begin
          if (txd == 1'b0) begin
            contig++;
            cnt = 0;
          end else begin
            active = 1'b0;
          end
        end
      end else if (txd == 1'b0) begin
        active = 1'b1;
        cnt = 0;
      end
    end
  end

  // RX monitor: every uart_out_ready pulse pops the scoreboard and compares the data.
  initial begin : rx_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_out_ready) begin
        out_pulses++;
        check("out_ready_one_cycle", {31'd0, prev}, 32'd0);
        check("rx_byte_expected", {31'd0, exp_rx.size() != 0}, 32'd1);
        if (exp_rx.size() != 0) check("rx_byte", {24'd0, uart_out_data}, {24'd0, exp_rx.pop_front()});
      end
      prev = uart_out_ready;
    end
  end

  task automatic send_out(input logic [7:0] b, output int waited);
    bit ok;
    ok = 1'b0; waited = 0;
    exp_tx.push_back(b);
    uart_in_data = b;
    uart_in_valid = 1'b1;
    while (!ok && waited < 400) begin
      @(negedge clk);
      if (uart_in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        waited++;
      end
    end
    uart_in_valid = 1'b0;
    check("in_ready_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i]; tick(CPB);
    end
    rxd = stop_bit; tick(CPB);
    rxd = 1'b1; tick(2 * CPB);
  endtask

  task automatic read_byte();
    bit ok;
    int w;
    ok = 1'b0; w = 0;
    uart_out_valid = 1'b1;
    while (!ok && w < 2000) begin
      @(negedge clk);
      if (uart_out_ready) ok = 1'b1;
      else w++;
    end
    uart_out_valid = 1'b0;
    check("out_ready_seen", {31'd0, ok}, 32'd1);
    tick(1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w, snap;
    logic [7:0] a5_bits;
    logic exp_bit;
    a5_bits = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_in_ready", {31'd0, uart_in_ready}, 32'd0);
    check("rst_out_ready", {31'd0, uart_out_ready}, 32'd0);
    check("rst_out_data", {24'd0, uart_out_data}, 32'd0);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_flags", {30'd0, rx_overrun, rx_frame_err}, 32'd0);
    reset = 1'b0;
    tick(3);

    // 1: single OUT byte, exact bit pattern and busy timing
    snap = in_pulses;
    send_out(8'hA5, w);
    check("t1_txd_idle_after_push", {31'd0, txd}, 32'd1);
    check("t1_busy_after_push", {31'd0, tx_busy}, 32'd1);
    @(posedge clk);
    for (int i = 0; i <= 80; i++) begin
      @(negedge clk);
      if (i < 80) begin
        if (i < 8) exp_bit = 1'b0;
        else if (i >= 72) exp_bit = 1'b1;
        else exp_bit = a5_bits[(i - 8) / 8];
        if (txd !== exp_bit) check("t1_txd_pattern", {31'd0, txd}, {31'd0, exp_bit});
      end
      if (i == 79) check("t1_busy_in_stop", {31'd0, tx_busy}, 32'd1);
      if (i == 80) check("t1_busy_after_stop", {31'd0, tx_busy}, 32'd0);
    end
    check("t1_ready_pulses", in_pulses - snap, 32'd1);
    tick(2);

    // 2: receive 0x3C then read it; data holds after ready drops
    exp_rx.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    read_byte();
    tick(4);
    check("t2_out_data_hold", {24'd0, uart_out_data}, 32'h3C);

    // 3: read request on empty RX blocks until a byte arrives
    snap = out_pulses;
    uart_out_valid = 1'b1;
    tick(30);
    check("t3_no_ready_when_empty", out_pulses - snap, 32'd0);
    exp_rx.push_back(8'h81);
    send_rx(8'h81, 1'b1);
    check("t3_ready_after_arrival", out_pulses - snap, 32'd1);
    uart_out_valid = 1'b0;
    tick(2);

    // 4: fill TX FIFO; sixth byte stalls; all frames contiguous
    snap = contig;
    for (int k = 0; k < 5; k++) begin
      send_out(8'h10 + 8'(k * 17), w);
      check("t4_accept_fast", {31'd0, w <= 2}, 32'd1);
    end
    send_out(8'hC3, w);
    check("t4_full_stall", {31'd0, w > 40}, 32'd1);
    w = 0;
    while (tx_busy && w < 1500) begin
      tick(1);
      w++;
    end
    check("t4_tx_drained", {31'd0, tx_busy}, 32'd0);
    tick(2);
    check("t4_contiguous_frames", contig - snap, 32'd5);
    check("t4_tx_queue_empty", exp_tx.size(), 32'd0);

    // 5: overrun, frame error and glitch rejection
    exp_rx.push_back(8'h11); exp_rx.push_back(8'h22);
    exp_rx.push_back(8'h33); exp_rx.push_back(8'h44);
    send_rx(8'h11, 1'b1); send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1); send_rx(8'h44, 1'b1);
    check("t5_no_overrun_at_full", {31'd0, rx_overrun}, 32'd0);
    send_rx(8'h55, 1'b1);
    check("t5_overrun", {31'd0, rx_overrun}, 32'd1);
    for (int k = 0; k < 4; k++) read_byte();
    check("t5_no_frame_err_yet", {31'd0, rx_frame_err}, 32'd0);
    send_rx(8'h99, 1'b0);
    check("t5_frame_err", {31'd0, rx_frame_err}, 32'd1);
    rxd = 1'b0; tick(1);
    rxd = 1'b1; tick(40);
    snap = out_pulses;
    uart_out_valid = 1'b1;
    tick(40);
    uart_out_valid = 1'b0;
    check("t5_rx_empty_after_err_glitch", out_pulses - snap, 32'd0);
    check("t5_overrun_sticky", {31'd0, rx_overrun}, 32'd1);
    check("t5_rx_queue_empty", exp_rx.size(), 32'd0);
    tick(2);

    // 6: reset in the middle of a TX frame
    send_out(8'hF0, w);
    tick(20);
    check("t6_mid_frame_low", {31'd0, txd}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_reset_txd_high", {31'd0, txd}, 32'd1);
    check("t6_reset_busy", {31'd0, tx_busy}, 32'd0);
    check("t6_reset_flags", {30'd0, rx_overrun, rx_frame_err}, 32'd0);
    exp_tx.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    w = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (txd == 1'b0) w++;
    end
    check("t6_tx_fifo_empty", w, 32'd0);
    check("t6_busy_stays_low", {31'd0, tx_busy}, 32'd0);

`ifdef UART_BRIDGE_LOOPBACK_EN
    loopback = 1'b1;
    tick(4);
    exp_rx.push_back(8'h5A);
    send_out(8'h5A, w);
    read_byte();
    loopback = 1'b0;
    check("t6_loopback_queue_empty", exp_rx.size(), 32'd0);
`endif

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
